pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised Y86-64 pipeline stage register; generalises the fixed per-stage registers (F/D/E/M/W) into one reusable block.
- Carries a stat/icode header plus a PAYLOAD_W-bit bundle (valE, valA, dstE, dstM, Cnd, ... packed by the instantiating stage).
- Adds hazard-unit stall/bubble control, asynchronous reset, and an optional sticky freeze on exception status (the W-stage halt behaviour).
- Optional performance counters.

Parameters:
- PAYLOAD_W, 137, width of the packed payload bundle (default fits the M stage: 1+64+64+4+4).
- BUBBLE_PAYLOAD, {PAYLOAD_W{1'b0}}, payload value loaded on reset or bubble; the instantiating stage sets dst fields to RNONE (4'hF).
- STAT_BUB, 3'd0, stat value marking an inserted bubble.
- STAT_AOK, 3'd1, normal-operation stat.
- ICODE_NOP, 4'h1, icode loaded on reset or bubble.
- FREEZE_ON_EXC, 0, 1 = freeze the register after loading an exception stat.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- stall  in  1  hold current contents
- bubble  in  1  load the NOP bubble
- in_stat  in  3  upstream status
- in_icode  in  4  upstream icode
- in_payload  in  PAYLOAD_W  upstream bundle
- out_stat  out  3  registered status
- out_icode  out  4  registered icode
- out_payload  out  PAYLOAD_W  registered bundle
- out_valid  out  1  1 = holds a real instruction, 0 = bubble
- frozen  out  1  sticky exception freeze
- ctrl_err  out  1  sticky: stall and bubble were asserted together
- stall_cnt  out  CNT_W  cycles with stall applied (PERF_CNT_EN only)
- bubble_cnt  out  CNT_W  bubbles inserted (PERF_CNT_EN only)

Behaviour:
- rst asserts asynchronously. While rst is high, every output holds its reset value:
  - out_stat=STAT_BUB, out_icode=ICODE_NOP, out_payload=BUBBLE_PAYLOAD
  - out_valid=0, frozen=0, ctrl_err=0, counters=0
- Latency is one cycle: the input sampled at a posedge is visible on the outputs after that edge.
- All outputs are registered; there is no combinational path from input to output.
- Per-posedge priority, highest first:
  1. frozen=1: hold all contents; ignore stall/bubble; counters do not change.
  2. bubble=1: load stat=STAT_BUB, icode=ICODE_NOP, payload=BUBBLE_PAYLOAD, out_valid=0.
  3. stall=1: hold all contents.
  4. Otherwise: load the in_* values; out_valid=1.
- stall and bubble high in the same cycle: bubble wins and ctrl_err sets. ctrl_err stays set until reset.
- Freeze:
  - Applies only when FREEZE_ON_EXC=1.
  - Triggered when a load (case 4) captures an in_stat other than STAT_AOK and other than STAT_BUB (HLT=2, ADR=3, INS=4, or any other value).
  - frozen rises in the same edge that captures that stat. The exception instruction therefore stays on the outputs.
  - Only rst clears frozen.
- With FREEZE_ON_EXC=0, frozen is tied to 0.
- A bubble load never sets frozen, even if in_stat carries an exception.
- Deasserting rst mid-operation: the first posedge after release performs a normal priority evaluation. No extra wait cycle is required.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each edge where case 3 applies.
  - bubble_cnt increments on each edge where case 2 applies.
  - Both saturate at all-ones without wrapping, and both reset to 0.
- Undefined: stall_cnt and bubble_cnt are driven with constant 0, and no counter flops are inferred.

Test Plan:
1. Reset and load: rst=1, then release, then load stat=1, icode=6, payload=0x1234. Reset outputs are stat=0, icode=1, valid=0. One cycle after the load: stat=1, icode=6, payload=0x1234, valid=1.
2. Stall: load icode=3, hold stall=1 for 3 cycles while the inputs change to icode=5. Outputs stay icode=3 for all 3 cycles. stall_cnt=3 when the macro is defined.
3. Bubble, and stall+bubble together:
   - bubble=1 with a valid input: stat=0, icode=1, valid=0, bubble_cnt=1.
   - Next cycle, stall=1 and bubble=1: bubble is inserted and ctrl_err=1, which stays set until rst.
4. Freeze (FREEZE_ON_EXC=1):
   - Load stat=2 (HLT), icode=0: frozen=1.
   - Further loads with stat=1, icode=6, and bubble=1, are ignored; outputs stay stat=2, icode=0.
   - Pulse rst: frozen=0 and reset values are restored.
5. Asynchronous reset mid-stream: assert rst between clock edges while valid=1. Outputs take reset values immediately, without waiting for clk.
6. Counter saturation: CNT_W=4 with the macro defined, stall held for 20 cycles. stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - hazard-control, data and status bundle of one Y86-64 pipeline stage register
//
// Purpose: groups every non-clock/reset signal of pipe_stage_reg so that a
// stage can be wired up with a single connection.
//
// Parameters (must match the attached pipe_stage_reg):
//   PAYLOAD_W  width of the packed payload bundle
//   CNT_W      performance counter width
//
// Signals:
//   stall, bubble                     hazard-unit controls into the register
//   in_stat, in_icode, in_payload     upstream stage values
//   out_stat, out_icode, out_payload  registered stage values
//   out_valid                         1 = real instruction, 0 = bubble
//   frozen, ctrl_err                  sticky status flags
//   stall_cnt, bubble_cnt             performance counters
//
// Modports:
//   master  upstream/hazard side: drives controls and inputs, observes outputs
//   slave   the register itself
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 137,
  parameter int CNT_W     = 32
);
  logic                 stall;
  logic                 bubble;
  logic [2:0]           in_stat;
  logic [3:0]           in_icode;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [2:0]           out_stat;
  logic [3:0]           out_icode;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_valid;
  logic                 frozen;
  logic                 ctrl_err;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output stall, bubble, in_stat, in_icode, in_payload,
    input  out_stat, out_icode, out_payload, out_valid, frozen, ctrl_err,
           stall_cnt, bubble_cnt
  );

  modport slave (
    input  stall, bubble, in_stat, in_icode, in_payload,
    output out_stat, out_icode, out_payload, out_valid, frozen, ctrl_err,
           stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised Y86-64 pipeline stage register with stall/bubble control
//
// Purpose: one reusable F/D/E/M/W pipeline register. Carries a stat/icode
// header plus a packed payload, obeys hazard-unit stall/bubble, and can
// optionally freeze once an exception status has been captured.
//
// Optional build macro: PIPE_STAGE_PERF_CNT_EN enables the saturating
// stall/bubble performance counters; when undefined they read as 0 and no
// counter flops exist.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipe_stage_reg_if.slave:
//          stall/bubble, in_stat/in_icode/in_payload       (inputs)
//          out_stat/out_icode/out_payload/out_valid         (registered)
//          frozen, ctrl_err, stall_cnt, bubble_cnt          (registered)
//
// Edge priority: frozen hold > bubble > stall hold > load.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W      = 137,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = {PAYLOAD_W{1'b0}},
  parameter logic [2:0]           STAT_BUB       = 3'd0,
  parameter logic [2:0]           STAT_AOK       = 3'd1,
  parameter logic [3:0]           ICODE_NOP      = 4'h1,
  parameter bit                   FREEZE_ON_EXC  = 1'b0,
  parameter int                   CNT_W          = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  logic [2:0]           stat_q;
  logic [3:0]           icode_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 valid_q;
  logic                 frozen_q;
  logic                 ctrl_err_q;

  // Main contents. A frozen register ignores the hazard unit entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q    <= STAT_BUB;
      icode_q   <= ICODE_NOP;
      payload_q <= BUBBLE_PAYLOAD;
      valid_q   <= 1'b0;
    end else if (!frozen_q) begin
      if (bus.bubble) begin
        stat_q    <= STAT_BUB;
        icode_q   <= ICODE_NOP;
        payload_q <= BUBBLE_PAYLOAD;
        valid_q   <= 1'b0;
      end else if (!bus.stall) begin
        stat_q    <= bus.in_stat;
        icode_q   <= bus.in_icode;
        payload_q <= bus.in_payload;
        valid_q   <= 1'b1;
      end
    end
  end

  // Simultaneous stall+bubble is a hazard-unit bug; remember it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_err_q <= 1'b0;
    end else if (!frozen_q && bus.bubble && bus.stall) begin
      ctrl_err_q <= 1'b1;
    end
  end

  // Sticky freeze: only a real load of an exception stat (not AOK, not a
  // bubble marker) sets it, so the faulting instruction stays visible.
  generate
    if (FREEZE_ON_EXC) begin : g_freeze
      logic load_exc;
      assign load_exc = !bus.bubble && !bus.stall &&
                        (bus.in_stat != STAT_AOK) && (bus.in_stat != STAT_BUB);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          frozen_q <= 1'b0;
        end else if (!frozen_q && load_exc) begin
          frozen_q <= 1'b1;
        end
      end
    end else begin : g_no_freeze
      assign frozen_q = 1'b0;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             stall_hit;
  logic             bubble_hit;

  // Counted events mirror the priority: a bubble edge is never a stall edge.
  assign bubble_hit = !frozen_q && bus.bubble;
  assign stall_hit  = !frozen_q && !bus.bubble && bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_hit && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bubble_hit && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`else
  assign bus.stall_cnt  = '0;
  assign bus.bubble_cnt = '0;
`endif

  assign bus.out_stat    = stat_q;
  assign bus.out_icode   = icode_q;
  assign bus.out_payload = payload_q;
  assign bus.out_valid   = valid_q;
  assign bus.frozen      = frozen_q;
  assign bus.ctrl_err    = ctrl_err_q;

endmodule
